// File: rtl/multi_motor_pwm_ramp.sv
// Multi-channel motor PWM driver with per-period slew limiting, protected
// direction reversal (brake, dead time, flip) and a global emergency stop.
module multi_motor_pwm_ramp #(
    parameter int CHANNELS     = 2,
    parameter int DUTY_W       = 10,
    parameter int PERIOD       = 4000,
    parameter int RAMP_STEP    = 8,
    parameter int DEAD_PERIODS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS*DUTY_W-1:0]   target_duty,
    input  logic [CHANNELS-1:0]          target_dir,
    input  logic                         load,
    input  logic                         estop,
    output logic [CHANNELS-1:0]          pwm,
    output logic [CHANNELS-1:0]          dir,
    output logic [CHANNELS-1:0]          at_target,
    output logic                         period_start
);

    localparam int CW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int PW  = $clog2(PERIOD + 1);
    localparam int DCW = (DEAD_PERIODS > 0) ? $clog2(DEAD_PERIODS + 1) : 1;

    localparam logic [CW-1:0]     CNT_LAST  = CW'(PERIOD - 1);
    localparam logic [PW-1:0]     PERIOD_L  = PW'(PERIOD);
    localparam logic [DUTY_W:0]   STEP      = (DUTY_W + 1)'(RAMP_STEP);
    localparam logic [DCW-1:0]    DEAD_INIT = DCW'(DEAD_PERIODS);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        BRAKE = 2'd1,
        DEAD  = 2'd2
    } state_t;

    logic [CW-1:0]     cnt;
    logic              boundary;

    logic [DUTY_W-1:0] tgt_duty   [CHANNELS];
    logic [CHANNELS-1:0] tgt_dir;

    logic [DUTY_W-1:0] cur_duty   [CHANNELS];
    logic [DUTY_W-1:0] cur_next   [CHANNELS];
    logic [CW-1:0]     thresh     [CHANNELS];
    logic [CW-1:0]     thresh_next[CHANNELS];
    state_t            state      [CHANNELS];
    state_t            state_next [CHANNELS];
    logic [DCW-1:0]    dcnt       [CHANNELS];
    logic [DCW-1:0]    dcnt_next  [CHANNELS];
    logic [CHANNELS-1:0] dir_next;
    logic [CHANNELS-1:0] pwm_next;

    assign boundary = (cnt == CNT_LAST);

    // Step cur toward tgt by at most RAMP_STEP; one spare bit catches wrap.
    function automatic logic [DUTY_W-1:0] ramp_toward(input logic [DUTY_W-1:0] cur,
                                                      input logic [DUTY_W-1:0] tgt);
        logic [DUTY_W:0] up;
        logic [DUTY_W:0] down;
        up   = {1'b0, cur} + STEP;
        down = {1'b0, cur} - STEP;
        if (cur < tgt)
            ramp_toward = (up > {1'b0, tgt}) ? tgt : up[DUTY_W-1:0];
        else if (cur > tgt)
            ramp_toward = (down[DUTY_W] || (down[DUTY_W-1:0] < tgt)) ? tgt : down[DUTY_W-1:0];
        else
            ramp_toward = cur;
    endfunction

    // Full-width product before the shift, so max duty still lands below PERIOD.
    function automatic logic [CW-1:0] duty_to_thresh(input logic [DUTY_W-1:0] duty);
        logic [DUTY_W+PW-1:0] prod;
        prod = {{PW{1'b0}}, duty} * {{DUTY_W{1'b0}}, PERIOD_L};
        duty_to_thresh = CW'(prod >> DUTY_W);
    endfunction

    // NOTE: every variable gets its hold value before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_next[i]  = state[i];
            cur_next[i]    = cur_duty[i];
            dcnt_next[i]   = dcnt[i];
            dir_next[i]    = dir[i];
            thresh_next[i] = thresh[i];
            pwm_next[i]    = !estop && (cnt < thresh[i]);

            if (estop) begin
                state_next[i]  = DEAD;
                cur_next[i]    = '0;
                dcnt_next[i]   = DEAD_INIT;
                thresh_next[i] = '0;
            end else if (boundary) begin
                case (state[i])
                    RUN: begin
                        if (tgt_dir[i] != dir[i])
                            state_next[i] = BRAKE;
                        else
                            cur_next[i] = ramp_toward(cur_duty[i], tgt_duty[i]);
                    end
                    BRAKE: begin
                        if (tgt_dir[i] == dir[i]) begin
                            state_next[i] = RUN;
                        end else begin
                            cur_next[i] = ramp_toward(cur_duty[i], '0);
                            if (cur_next[i] == '0) begin
                                state_next[i] = DEAD;
                                dcnt_next[i]  = DEAD_INIT;
                            end
                        end
                    end
                    DEAD: begin
                        cur_next[i] = '0;
                        if (dcnt[i] <= DCW'(1)) begin
                            dir_next[i]   = tgt_dir[i];
                            state_next[i] = RUN;
                        end else begin
                            dcnt_next[i] = dcnt[i] - DCW'(1);
                        end
                    end
                    default: state_next[i] = RUN;
                endcase
                thresh_next[i] = duty_to_thresh(cur_next[i]);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++)
            at_target[i] = (state[i] == RUN) && (cur_duty[i] == tgt_duty[i]) &&
                           (dir[i] == tgt_dir[i]);
    end

    // NOTE: all state here is a handful of flops per channel, so every array
    // element is reset; non-blocking assignments keep the update order-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            period_start <= 1'b0;
            pwm          <= '0;
            dir          <= '0;
            tgt_dir      <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                tgt_duty[i] <= '0;
                cur_duty[i] <= '0;
                thresh[i]   <= '0;
                state[i]    <= RUN;
                dcnt[i]     <= '0;
            end
        end else begin
            cnt          <= boundary ? '0 : cnt + CW'(1);
            period_start <= (cnt == '0);
            pwm          <= pwm_next;
            dir          <= dir_next;
            if (load)
                tgt_dir <= target_dir;
            for (int i = 0; i < CHANNELS; i++) begin
                if (load)
                    tgt_duty[i] <= target_duty[i*DUTY_W +: DUTY_W];
                cur_duty[i] <= cur_next[i];
                thresh[i]   <= thresh_next[i];
                state[i]    <= state_next[i];
                dcnt[i]     <= dcnt_next[i];
            end
        end
    end

endmodule
